// File: rtl/hdr_fifo_reader.sv
// Read-side controller for the channel header FIFO: pops one header, waits out the
// FIFO read latency, captures it and streams it MSW-first as WORD_WIDTH-bit words.
module hdr_fifo_reader #(
    parameter int HDR_WIDTH  = 108,
    parameter int WORD_WIDTH = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [HDR_WIDTH-1:0]  fifo_dout,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           hdr_count
);

    localparam int N_WORDS = (HDR_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int PAD_W   = N_WORDS * WORD_WIDTH;
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PAD_W-1:0]      hdr_q, hdr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  m_valid_q, m_valid_d;
    logic [WORD_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic [15:0]           hdr_count_q, hdr_count_d;

    logic [PAD_W-1:0]      dout_pad_s;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic                  idx_is_last_s;
    logic                  cnt_zero_s;

    // Word k of the left-zero-padded header, most significant word first.
    function automatic logic [WORD_WIDTH-1:0] word_sel(input logic [PAD_W-1:0] p,
                                                        input logic [IDX_W-1:0] k);
        logic [PAD_W-1:0] sh;
        sh = p << (32'(k) * WORD_WIDTH);
        return sh[PAD_W-1 -: WORD_WIDTH];
    endfunction

    assign dout_pad_s    = PAD_W'(fifo_dout);
    assign idx_nxt_s     = idx_q + IDX_W'(1);
    assign idx_is_last_s = (idx_q == IDX_W'(N_WORDS - 1));
    assign cnt_zero_s    = (cnt_q == CNT_W'(0));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_POP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: state_d = S_WAIT;
            S_WAIT: begin
                if (cnt_zero_s) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SEND: begin
                if (m_ready && idx_is_last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are loaded one edge ahead so they leave registers.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        hdr_d       = hdr_q;
        rd_en_d     = 1'b0;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        hdr_count_d = hdr_count_q;
        case (state_q)
            S_IDLE: begin
                rd_en_d   = !fifo_empty;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
            S_POP: begin
                cnt_d = CNT_W'(RD_LATENCY - 1);
            end
            S_WAIT: begin
                if (cnt_zero_s) begin
                    hdr_d     = dout_pad_s;
                    idx_d     = IDX_W'(0);
                    m_valid_d = 1'b1;
                    m_data_d  = word_sel(dout_pad_s, IDX_W'(0));
                    m_last_d  = (N_WORDS == 1) ? 1'b1 : 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SEND: begin
                if (m_ready) begin
                    if (idx_is_last_s) begin
                        hdr_count_d = hdr_count_q + 16'd1;
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                        m_data_d    = '0;
                    end else begin
                        idx_d    = idx_nxt_s;
                        m_data_d = word_sel(hdr_q, idx_nxt_s);
                        m_last_d = (idx_nxt_s == IDX_W'(N_WORDS - 1)) ? 1'b1 : 1'b0;
                    end
                end else begin
                    m_valid_d = 1'b1;
                end
            end
            default: begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            hdr_q       <= '0;
            rd_en_q     <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            hdr_count_q <= 16'd0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hdr_q       <= hdr_d;
            rd_en_q     <= rd_en_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            hdr_count_q <= hdr_count_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign busy       = (state_q != S_IDLE);
    assign hdr_count  = hdr_count_q;

endmodule

// File: tb/tb_hdr_fifo_reader.sv
// Scoreboard bench for hdr_fifo_reader: a latency-accurate FIFO model feeds headers,
// expected words are queued at push time and a monitor checks every accepted word.
module tb_hdr_fifo_reader;

    localparam int HW     = 108;
    localparam int WW     = 16;
    localparam int RL     = 2;
    localparam int NW     = (HW + WW - 1) / WW;
    localparam int PW     = NW * WW;
    localparam int PERIOD = 1 + 1 + RL + NW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [HW-1:0] fifo_dout = '0;
    logic [WW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          busy;
    logic [15:0]   hdr_count;

    int checks = 0;
    int errors = 0;

    logic [HW-1:0] fifo_q[$];
    logic [WW:0]   exp_q[$];
    logic [HW-1:0] pipe_d[RL];
    logic          pipe_v[RL];
    logic [15:0]   model_cnt = 16'd0;
    int            words_in_hdr = 0;
    int            ready_mode = 3;
    int            cyc = 0;
    int            last_rd_cyc = -1;
    bit            check_spacing = 1'b0;

    localparam logic [HW-1:0] H1 = 108'h123_4567_89AB_CDEF_0123_4567_89AB;

    always #5 clk = ~clk;

    hdr_fifo_reader #(.HDR_WIDTH(HW), .WORD_WIDTH(WW), .RD_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .hdr_count(hdr_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Queue a header into the FIFO and its expected word sequence into the scoreboard.
    task automatic push_hdr(input logic [HW-1:0] h);
        logic [PW-1:0] p;
        logic [PW-1:0] w;
        fifo_q.push_back(h);
        fifo_empty = 1'b0;
        p = PW'(h);
        for (int k = 0; k < NW; k++) begin
            w = p >> ((NW - 1 - k) * WW);
            exp_q.push_back({(k == NW - 1), w[WW-1:0]});
        end
    endtask

    function automatic logic [HW-1:0] rand_hdr();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[HW-1:0];
    endfunction

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending words, required=0", exp_q.size());
        end
        @(negedge clk);
        #1;
    endtask

    // FIFO model: data appears RL edges after the edge that sampled the pop, junk otherwise.
    initial begin
        logic          rd_s;
        logic [127:0]  junk;
        for (int i = 0; i < RL; i++) pipe_v[i] = 1'b0;
        forever begin
            @(negedge clk);
            rd_s = fifo_rd_en;
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < RL; i++) pipe_v[i] = 1'b0;
            end else begin
                for (int i = RL - 1; i > 0; i--) begin
                    pipe_v[i] = pipe_v[i-1];
                    pipe_d[i] = pipe_d[i-1];
                end
                pipe_v[0] = 1'b0;
                if (rd_s && fifo_q.size() > 0) begin
                    pipe_d[0] = fifo_q.pop_front();
                    pipe_v[0] = 1'b1;
                end
            end
            fifo_empty = (fifo_q.size() == 0);
            if (pipe_v[RL-1]) begin
                fifo_dout = pipe_d[RL-1];
            end else begin
                junk = {$urandom, $urandom, $urandom, $urandom};
                fifo_dout = junk[HW-1:0];
            end
        end
    end

    // Downstream ready driver.
    initial begin
        int pat = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 9) < 6);
                2: begin m_ready = (pat % 3 == 0); pat++; end
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every offered word against the scoreboard head.
    initial begin
        bit       stalled = 1'b0;
        bit       prd = 1'b0;
        bit       cnt_pend = 1'b0;
        logic [WW:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
                prd = 1'b0;
                cnt_pend = 1'b0;
            end else begin
                if (cnt_pend) begin
                    check("hdr_count", hdr_count, model_cnt);
                    check("busy_after_hdr", busy, 1'b0);
                    cnt_pend = 1'b0;
                end
                if (stalled) check("valid_held", m_valid, 1'b1);
                if (fifo_rd_en) begin
                    check("rd_en_width", prd, 1'b0);
                    if (!prd) begin
                        if (check_spacing && last_rd_cyc >= 0)
                            check("rd_spacing", cyc - last_rd_cyc, PERIOD);
                        last_rd_cyc = cyc;
                    end
                end
                prd = fifo_rd_en;
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word actual=%0h required=none", m_data);
                    end else begin
                        e = exp_q[0];
                        check("word_data", m_data, e[WW-1:0]);
                        check("word_last", m_last, e[WW]);
                        if (m_ready) begin
                            void'(exp_q.pop_front());
                            words_in_hdr++;
                            if (e[WW]) begin
                                model_cnt++;
                                words_in_hdr = 0;
                                cnt_pend = 1'b1;
                            end
                        end
                    end
                end
                stalled = m_valid && !m_ready;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset with a header waiting, then check the pop/capture timing.
        push_hdr(H1);
        ready_mode = 0;
        repeat (2) @(negedge clk);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, 16'h0000);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_hdr_count", hdr_count, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("pop_first_edge", fifo_rd_en, 1'b1);
        @(negedge clk);
        check("pop_one_cycle", fifo_rd_en, 1'b0);
        check("valid_before_capture", m_valid, 1'b0);
        for (int i = 1; i < RL; i++) begin
            @(negedge clk);
            check("valid_before_capture", m_valid, 1'b0);
        end
        @(negedge clk);
        check("valid_after_capture", m_valid, 1'b1);
        check("first_word", m_data, 16'h0123);
        wait_drain(100);
        check("count_one", hdr_count, 16'd1);

        // Same header with a stalling consumer.
        ready_mode = 2;
        push_hdr(H1);
        wait_drain(200);

        // Back-to-back headers: pop pulses spaced by one full header period.
        ready_mode = 0;
        last_rd_cyc = -1;
        check_spacing = 1'b1;
        for (int i = 0; i < 3; i++) push_hdr(rand_hdr());
        wait_drain(200);
        check_spacing = 1'b0;
        check("count_after_burst", hdr_count, 16'd5);
        check("idle_busy", busy, 1'b0);
        check("idle_empty", fifo_empty, 1'b1);

        // Asynchronous reset in the middle of a header.
        push_hdr(rand_hdr());
        n = 0;
        while (words_in_hdr != 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_word3", words_in_hdr, 3);
        #1;
        rst = 1'b1;
        #1;
        check("async_m_valid", m_valid, 1'b0);
        check("async_m_last", m_last, 1'b0);
        check("async_m_data", m_data, 16'h0000);
        check("async_rd_en", fifo_rd_en, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_hdr_count", hdr_count, 16'h0000);
        while (exp_q.size() != 0) begin
            logic [WW:0] d;
            d = exp_q.pop_front();
            if (d[WW]) break;
        end
        model_cnt = 16'd0;
        words_in_hdr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_hdr(rand_hdr());
        wait_drain(100);

        // Randomized traffic with random backpressure and gaps.
        ready_mode = 1;
        for (int i = 0; i < 20; i++) begin
            push_hdr(rand_hdr());
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        wait_drain(2000);

        // Counter wrap from 65535 to 0.
        ready_mode = 0;
        @(negedge clk);
        force dut.hdr_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.hdr_count_q;
        model_cnt = 16'hFFFF;
        check("preload_count", hdr_count, 16'hFFFF);
        push_hdr(rand_hdr());
        wait_drain(100);
        check("count_wrap", hdr_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
